conv33_linebuf: RTL
===================

// Module: conv33_linebuf
// PURPOSE
//  Input stage upstream of the 3x3 conv controller. Takes a raster-order pixel
//  stream and builds 3x3 windows using two line buffers and a 3x3 shift window.
//  It hands one complete window to the conv datapath per LOAD_I handshake:
//  inputbuf_read_en comes in, input_ready goes out.
//  The window is held stable until the controller next requests data.
// PARAMETERS
//  DATA_W  8  pixel width in bits
//  IMG_W   8  pixels per row (>=3)
//  IMG_H   8  rows per frame (>=3)
//  CW = $clog2(IMG_W), RW = $clog2(IMG_H) (localparams)
// PORTS
//  clk               in   1         single clock, rising edge
//  rst               in   1         asynchronous, active-low reset
//  pix_valid         in   1         upstream pixel valid
//  pix_data          in   DATA_W    upstream pixel, raster order
//  pix_ready         out  1         pixel accepted when pix_valid & pix_ready
//  inputbuf_read_en  in   1         controller LOAD_I request (level)
//  input_ready       out  1         1-cycle pulse: new window valid
//  window            out  9*DATA_W  window[DATA_W*(3*r+c) +: DATA_W]; r0=oldest row, c0=leftmost
//  win_row           out  RW        top-left row of held window
//  win_col           out  CW        top-left column of held window
//  frame_done        out  1         1-cycle pulse after last pixel of frame accepted
// BEHAVIOUR
//  Reset:
//  - All outputs, window, counters, state and the inputbuf_read_en delay reg are 0.
//  - State is FILL. Line-buffer RAM is not reset.
//  States:
//  - FILL: pix_ready = inputbuf_read_en (combinational). HOLD: pix_ready = 0.
//  Accept (pix_valid & pix_ready), at column col and row row:
//  - Shift the window left by one column.
//  - New right column is {top=lb1[col], mid=lb0[col], bot=pix_data}.
//  - lb1[col] <= lb0[col]; lb0[col] <= pix_data.
//  - col++. At IMG_W-1, col wraps to 0 and row++.
//  - At (IMG_H-1, IMG_W-1), row and col wrap to 0 and frame_done pulses next cycle.
//  Window completion (accept with row>=2 and col>=2):
//  - Next cycle: state becomes HOLD and input_ready = 1 for exactly one cycle.
//  - Same cycle: win_row = row-2 and win_col = col-2 are registered.
//  - Latency: accept edge -> window/input_ready valid is 1 cycle.
//  - Accepts with col<2 or row<2 update buffers only; windows holding row-wrap data never flag.
//  HOLD:
//  - window, win_row and win_col are frozen.
//  - Leave to FILL on a rising edge of inputbuf_read_en (high now, low last cycle).
//  - pix_ready stays 0 in that transition cycle and rises in the next FILL cycle.
//  - If inputbuf_read_en never drops, stay in HOLD; a stale window is never re-flagged.
//  Stall and boundary rules:
//  - pix_valid while pix_ready=0: ignored, no state change.
//  - Bubbles (pix_valid low) between pixels are allowed.
//  - Last pixel of a frame completes a window: input_ready and frame_done pulse in the same cycle.
//  - Windows per frame = (IMG_H-2)*(IMG_W-2).
//  - Reset asserted mid-frame: immediate return to reset values; the next accepted pixel is (0,0).
//  No arithmetic on pixel data; data is moved bit-exact.
// TESTING (IMG_W=5, IMG_H=4, DATA_W=8, pixel(r,c)=16*r+c)
//  1 read_en held high, pix_valid continuous:
//    - First input_ready one cycle after 13th accept (r2,c2).
//    - window = 00,01,02,10,11,12,20,21,22 (c0..c2 per row); win_row=0, win_col=0.
//  2 Full controller loop (drop read_en 3 cycles per window, then re-raise):
//    - Exactly 6 input_ready pulses; win_col sequence 0,1,2,0,1,2.
//    - frame_done coincides with the 6th pulse; 20 pixels accepted.
//  3 In HOLD with pix_valid held high for 10 cycles:
//    - pix_ready=0 and window unchanged.
//    - No extra pulse until a read_en 0->1 edge.
//  4 Random pix_valid bubbles (~50%): window contents and count identical to scenario 2.
//  5 Reset low after 8 accepts, then release:
//    - All outputs 0.
//    - New frame from (0,0) gives first window 00..22 again.
//  6 Two back-to-back frames: 12 pulses, 2 frame_done; first window of frame 2 has no frame-1 data.

Source files
------------

// File: rtl/conv33_linebuf.sv
`default_nettype none
// ============================================================================
// Module      : conv33_linebuf
// Description : Raster pixel stream to 3x3 window builder. Two line buffers
//               plus a 3x3 shift window; one complete window is handed to the
//               conv controller per LOAD_I handshake and held until the
//               controller asks again.
// Revision    : 1.0 - initial release
// ============================================================================
module conv33_linebuf #(
  parameter  int DATA_W = 8,
  parameter  int IMG_W  = 8,
  parameter  int IMG_H  = 8,
  localparam int CW     = $clog2(IMG_W),
  localparam int RW     = $clog2(IMG_H)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pix_valid,
  input  logic [DATA_W-1:0]   pix_data,
  output logic                pix_ready,
  input  logic                inputbuf_read_en,
  output logic                input_ready,
  output logic [9*DATA_W-1:0] window,
  output logic [RW-1:0]       win_row,
  output logic [CW-1:0]       win_col,
  output logic                frame_done
);

  localparam logic [0:0]    c_fill     = 1'b0;
  localparam logic [0:0]    c_hold     = 1'b1;
  localparam logic [CW-1:0] c_col_last = CW'(IMG_W - 1);
  localparam logic [RW-1:0] c_row_last = RW'(IMG_H - 1);
  localparam logic [CW-1:0] c_col_two  = CW'(2);
  localparam logic [RW-1:0] c_row_two  = RW'(2);

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic              r_rd_en_d;
  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [DATA_W-1:0] r_lb0 [IMG_W];
  logic [DATA_W-1:0] r_lb1 [IMG_W];
  logic [DATA_W-1:0] r_win [9];

  logic w_accept;
  logic w_col_last;
  logic w_row_last;
  logic w_win_done;
  logic w_rd_rise;

  assign w_accept   = pix_valid & pix_ready;
  assign w_col_last = (r_col == c_col_last);
  assign w_row_last = (r_row == c_row_last);
  // Columns 0/1 of a row still hold the previous row's tail, so only col>=2 flags.
  assign w_win_done = w_accept & (r_row >= c_row_two) & (r_col >= c_col_two);
  assign w_rd_rise  = inputbuf_read_en & ~r_rd_en_d;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_fill;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: park in HOLD after each window, resume on a new read request edge
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_fill:  if (w_win_done) w_state_nxt = c_hold;
      c_hold:  if (w_rd_rise)  w_state_nxt = c_fill;
      default: w_state_nxt = c_fill;
    endcase
  end

  // Output decode: upstream may only push while filling and the controller is asking
  always_comb begin
    pix_ready = 1'b0;
    if (r_state == c_fill) pix_ready = inputbuf_read_en;
  end

  // Line-buffer storage; contents are overwritten before use so no reset is needed
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= pix_data;
    end
  end

  // Raster counters, shift window, window coordinates and status pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_en_d   <= 1'b0;
      r_col       <= '0;
      r_row       <= '0;
      win_row     <= '0;
      win_col     <= '0;
      input_ready <= 1'b0;
      frame_done  <= 1'b0;
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
    end else begin
      r_rd_en_d   <= inputbuf_read_en;
      input_ready <= w_win_done;
      frame_done  <= w_accept & w_col_last & w_row_last;
      if (w_accept) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= r_lb1[r_col];
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= r_lb0[r_col];
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= pix_data;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      if (w_win_done) begin
        win_row <= r_row - c_row_two;
        win_col <= r_col - c_col_two;
      end
    end
  end

  for (genvar gi = 0; gi < 9; gi++) begin : g_win
    assign window[DATA_W*gi +: DATA_W] = r_win[gi];
  end

endmodule
`default_nettype wire
